cdm8_err_stats: RTL and testbench
=================================

Name: cdm8_err_stats

Overview:
- Downstream consumer of the cdm8_aa 8x8 approximate multiplier output stream.
- Takes (a, b, r_approx) triples under a valid/ready handshake and computes the exact product internally.
- Accumulates error statistics over a run of N samples: sample count, erroneous count, sum of error distance, maximum error distance and the operands that produced it.
- Replaces offline text-dump post-processing with on-chip error metrics (MED = sum_ed / sample_cnt, error rate = err_cnt / sample_cnt).

Parameters:
- SUM_W, 32, width of the error-distance accumulator; saturates at all-ones if exceeded.
- CNT_W, 17, width of the sample and error counters and of n_samples (17 bits covers the full 65536-pair sweep).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; latches n_samples, clears stats, begins run (honoured only in IDLE or DONE)
- n_samples  in  CNT_W  number of triples to accept in this run
- in_valid  in  1  upstream triple valid
- in_ready  out  1  block can accept a triple
- a  in  8  multiplicand applied to the multiplier
- b  in  8  multiplier applied to the multiplier
- r  in  16  approximate product from the multiplier
- busy  out  1  high in RUN and DRAIN
- done  out  1  one-cycle pulse when the final sample is accounted for
- sample_cnt  out  CNT_W  samples accumulated
- err_cnt  out  CNT_W  samples with r != a*b
- sum_ed  out  SUM_W  sum of |a*b - r|
- max_ed  out  16  largest |a*b - r| seen
- max_a  out  8  a of the first sample reaching max_ed
- max_b  out  8  b of the first sample reaching max_ed

Behaviour:
- Reset: state = IDLE. Every output, internal register and pipeline valid bit is cleared to 0.
- FSM has four states: IDLE, RUN, DRAIN, DONE.
  - IDLE/DONE, start=1: latch n_samples, clear all stats, set accepted count to 0, go to RUN.
  - RUN: when the accepted count equals the latched n_samples, go to DRAIN. This includes n_samples=0, where RUN lasts exactly 1 cycle.
  - DRAIN: when both pipeline stages are empty, assert done for 1 cycle and go to DONE.
  - DONE: stats hold until the next start. DONE otherwise behaves like IDLE.
- in_ready = (state==RUN) && (accepted < n_samples). It is combinational from state and counter only, never from in_valid.
- A transfer occurs on a cycle with in_valid && in_ready. in_valid without in_ready is ignored; nothing is queued.
- Pipeline (always advances, no backpressure inside):
  - S1 registers a, b, r and valid.
  - S2 registers exact = a*b (16 bits unsigned), ed = |exact - r| (16 bits unsigned), and the flag ed!=0.
  - S3 updates the accumulators.
- Latency: a triple accepted at edge k appears in the stats after edge k+2.
- Accumulator update on S3 valid:
  - sample_cnt += 1.
  - err_cnt += (ed != 0).
  - sum_ed += ed, saturating at 2^SUM_W - 1.
  - If ed > max_ed, update max_ed, max_a and max_b. A tie keeps the earlier sample.
- start while busy is ignored; it neither restarts nor relatches.
- rst mid-run aborts immediately to IDLE with all stats cleared. No done pulse is issued.
- Back-to-back runs: start in DONE on the same cycle the done pulse has already passed is legal.

Optional Feature:
- Macro: CDM_ERR_BIAS_EN.
- Defined:
  - Adds output bias_sum (signed, SUM_W+1 bits), which accumulates the signed error (r - exact).
  - Saturates symmetrically at the signed limits.
  - Cleared by rst and by start.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Exact results: start with n_samples=4; feed (3,5,15), (255,255,65025), (0,7,0), (16,16,256) with in_valid held high. Required: sample_cnt=4, err_cnt=0, sum_ed=0, max_ed=0; done pulses once, 2 cycles after the last accept plus the DRAIN exit.
- Errors: n_samples=3; feed (10,10,96), (200,3,608), (12,12,144). Required: err_cnt=2, sum_ed=12, max_ed=8, max_a=200, max_b=3. With CDM_ERR_BIAS_EN: bias_sum=+4.
- Handshake: n_samples=2 with in_valid toggled every other cycle. Required: exactly 2 transfers; in_ready is low from the cycle after the 2nd accept; extra valid triples are dropped and not counted.
- n_samples=0: start. Required: no in_ready assertion; done pulses within 3 cycles; all stats read 0.
- Abort: rst asserted while in RUN after 5 of 10 samples. Required: next cycle state=IDLE, all outputs 0, no done. A following start then runs a clean 10-sample pass.
- Full sweep: n_samples=65536, all (a,b) pairs driven from the cdm8_aa output. Required: sample_cnt=65536, and err_cnt and sum_ed match the software model of the same multiplier.

Source files
------------

// File: rtl/cdm8_err_stats.sv
// Error-statistics accumulator for the cdm8_aa approximate multiplier stream.
// Define CDM_ERR_BIAS_EN to add the signed bias accumulator output bias_sum.
module cdm8_err_stats #(
  parameter int SUM_W = 32,
  parameter int CNT_W = 17
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] n_samples,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       a,
  input  logic [7:0]       b,
  input  logic [15:0]      r,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] sample_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [SUM_W-1:0] sum_ed,
  output logic [15:0]      max_ed,
  output logic [7:0]       max_a,
  output logic [7:0]       max_b
`ifdef CDM_ERR_BIAS_EN
  ,
  output logic signed [SUM_W:0] bias_sum
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Unsigned accumulate that sticks at all-ones instead of wrapping.
  function automatic logic [SUM_W-1:0] sat_add_u(input logic [SUM_W-1:0] acc,
                                                 input logic [15:0]      inc);
    logic [SUM_W:0] s;
    s = {1'b0, acc} + {{(SUM_W-15){1'b0}}, inc};
    return s[SUM_W] ? {SUM_W{1'b1}} : s[SUM_W-1:0];
  endfunction

  function automatic logic [15:0] abs_diff(input logic [15:0] x, input logic [15:0] y);
    return (x >= y) ? (x - y) : (y - x);
  endfunction

`ifdef CDM_ERR_BIAS_EN
  // Signed accumulate clamped symmetrically to the SUM_W+1 bit two's-complement range.
  function automatic logic signed [SUM_W:0] sat_add_s(input logic signed [SUM_W:0] acc,
                                                      input logic signed [16:0]    inc);
    logic signed [SUM_W+1:0] s;
    s = $signed({acc[SUM_W], acc}) + $signed({{(SUM_W-15){inc[16]}}, inc});
    if (s[SUM_W+1] != s[SUM_W]) begin
      return s[SUM_W+1] ? $signed({1'b1, {SUM_W{1'b0}}}) : $signed({1'b0, {SUM_W{1'b1}}});
    end
    return s[SUM_W:0];
  endfunction
`endif

  state_t           state_q, state_d;
  logic [CNT_W-1:0] n_q, n_d;
  logic [CNT_W-1:0] acc_q, acc_d;
  logic             done_q, done_d;
  logic             xfer;
  logic             clr_stats;

  logic             vld_p1_q, vld_p1_d;
  logic [7:0]       a_p1_q, a_p1_d;
  logic [7:0]       b_p1_q, b_p1_d;
  logic [15:0]      r_p1_q, r_p1_d;

  logic [15:0]      exact_p1;
  logic             vld_p2_q, vld_p2_d;
  logic [7:0]       a_p2_q, a_p2_d;
  logic [7:0]       b_p2_q, b_p2_d;
  logic [15:0]      ed_p2_q, ed_p2_d;
  logic             err_p2_q, err_p2_d;

  logic [CNT_W-1:0] sample_q, sample_d;
  logic [CNT_W-1:0] errc_q, errc_d;
  logic [SUM_W-1:0] sum_q, sum_d;
  logic [15:0]      max_ed_q, max_ed_d;
  logic [7:0]       max_a_q, max_a_d;
  logic [7:0]       max_b_q, max_b_d;

`ifdef CDM_ERR_BIAS_EN
  logic signed [16:0]    sd_p2_q, sd_p2_d;
  logic signed [SUM_W:0] bias_q, bias_d;
`endif

  // Control: run sequencing and the accept counter.
  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    acc_d     = acc_q;
    done_d    = 1'b0;
    clr_stats = 1'b0;
    in_ready  = (state_q == RUN) && (acc_q < n_q);
    xfer      = in_valid && in_ready;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          n_d       = n_samples;
          acc_d     = '0;
          clr_stats = 1'b1;
          state_d   = RUN;
        end
      end
      RUN: begin
        if (xfer) acc_d = acc_q + CNT_W'(1);
        if (acc_q == n_q) state_d = DRAIN;
      end
      DRAIN: begin
        if (!vld_p1_q && !vld_p2_q) begin
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // S1 -> S2: exact product and error distance.
  always_comb begin
    vld_p1_d = xfer;
    a_p1_d   = a;
    b_p1_d   = b;
    r_p1_d   = r;

    exact_p1 = 16'(a_p1_q) * 16'(b_p1_q);
    vld_p2_d = vld_p1_q;
    a_p2_d   = a_p1_q;
    b_p2_d   = b_p1_q;
    ed_p2_d  = abs_diff(exact_p1, r_p1_q);
    err_p2_d = (exact_p1 != r_p1_q);
`ifdef CDM_ERR_BIAS_EN
    sd_p2_d  = $signed({1'b0, r_p1_q}) - $signed({1'b0, exact_p1});
`endif
  end

  // S2 -> S3: statistics update; a tie on max_ed keeps the earlier sample.
  always_comb begin
    sample_d = sample_q;
    errc_d   = errc_q;
    sum_d    = sum_q;
    max_ed_d = max_ed_q;
    max_a_d  = max_a_q;
    max_b_d  = max_b_q;
`ifdef CDM_ERR_BIAS_EN
    bias_d   = bias_q;
`endif
    if (clr_stats) begin
      sample_d = '0;
      errc_d   = '0;
      sum_d    = '0;
      max_ed_d = '0;
      max_a_d  = '0;
      max_b_d  = '0;
`ifdef CDM_ERR_BIAS_EN
      bias_d   = '0;
`endif
    end else if (vld_p2_q) begin
      sample_d = sample_q + CNT_W'(1);
      errc_d   = errc_q + CNT_W'(err_p2_q);
      sum_d    = sat_add_u(sum_q, ed_p2_q);
      if (ed_p2_q > max_ed_q) begin
        max_ed_d = ed_p2_q;
        max_a_d  = a_p2_q;
        max_b_d  = b_p2_q;
      end
`ifdef CDM_ERR_BIAS_EN
      bias_d   = sat_add_s(bias_q, sd_p2_q);
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      n_q      <= '0;
      acc_q    <= '0;
      done_q   <= 1'b0;
      vld_p1_q <= 1'b0;
      a_p1_q   <= '0;
      b_p1_q   <= '0;
      r_p1_q   <= '0;
      vld_p2_q <= 1'b0;
      a_p2_q   <= '0;
      b_p2_q   <= '0;
      ed_p2_q  <= '0;
      err_p2_q <= 1'b0;
      sample_q <= '0;
      errc_q   <= '0;
      sum_q    <= '0;
      max_ed_q <= '0;
      max_a_q  <= '0;
      max_b_q  <= '0;
`ifdef CDM_ERR_BIAS_EN
      sd_p2_q  <= '0;
      bias_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      n_q      <= n_d;
      acc_q    <= acc_d;
      done_q   <= done_d;
      vld_p1_q <= vld_p1_d;
      a_p1_q   <= a_p1_d;
      b_p1_q   <= b_p1_d;
      r_p1_q   <= r_p1_d;
      vld_p2_q <= vld_p2_d;
      a_p2_q   <= a_p2_d;
      b_p2_q   <= b_p2_d;
      ed_p2_q  <= ed_p2_d;
      err_p2_q <= err_p2_d;
      sample_q <= sample_d;
      errc_q   <= errc_d;
      sum_q    <= sum_d;
      max_ed_q <= max_ed_d;
      max_a_q  <= max_a_d;
      max_b_q  <= max_b_d;
`ifdef CDM_ERR_BIAS_EN
      sd_p2_q  <= sd_p2_d;
      bias_q   <= bias_d;
`endif
    end
  end

  assign busy       = (state_q == RUN) || (state_q == DRAIN);
  assign done       = done_q;
  assign sample_cnt = sample_q;
  assign err_cnt    = errc_q;
  assign sum_ed     = sum_q;
  assign max_ed     = max_ed_q;
  assign max_a      = max_a_q;
  assign max_b      = max_b_q;
`ifdef CDM_ERR_BIAS_EN
  assign bias_sum   = bias_q;
`endif

endmodule

// File: tb/tb_cdm8_err_stats.sv
// Self-checking bench for cdm8_err_stats: fixed vectors, abort, saturation and random runs.
// A second instance with a narrow accumulator exercises saturation of sum_ed (and bias_sum).
module tb_cdm8_err_stats;
  localparam int CNT_W  = 17;
  localparam int SUM_W  = 32;
  localparam int SUM2_W = 17;

  localparam longint SUM_MAX  = (64'sd1 <<< SUM_W) - 1;
  localparam longint SUM2_MAX = (64'sd1 <<< SUM2_W) - 1;
  localparam longint B_MAX    = (64'sd1 <<< SUM_W) - 1;
  localparam longint B_MIN    = -(64'sd1 <<< SUM_W);
  localparam longint B2_MAX   = (64'sd1 <<< SUM2_W) - 1;
  localparam longint B2_MIN   = -(64'sd1 <<< SUM2_W);

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] r;
  } trip_t;

  typedef struct {
    int               n;
    int               nt;
    bit               tog;
    logic [3:0][7:0]  ta;
    logic [3:0][7:0]  tb;
    logic [3:0][15:0] tr;
    longint           e_samp, e_err, e_sum, e_max, e_ma, e_mb, e_bias;
  } vec_t;

  logic             clk = 1'b0;
  logic             rst, start, in_valid;
  logic [CNT_W-1:0] n_samples;
  logic [7:0]       a, b;
  logic [15:0]      r;
  logic             in_ready, busy, done;
  logic [CNT_W-1:0] sample_cnt, err_cnt;
  logic [SUM_W-1:0] sum_ed;
  logic [15:0]      max_ed;
  logic [7:0]       max_a, max_b;
  logic             in_ready2, busy2, done2;
  logic [CNT_W-1:0] sample_cnt2, err_cnt2;
  logic [SUM2_W-1:0] sum_ed2;
  logic [15:0]      max_ed2;
  logic [7:0]       max_a2, max_b2;
`ifdef CDM_ERR_BIAS_EN
  logic signed [SUM_W:0]  bias_sum;
  logic signed [SUM2_W:0] bias_sum2;
`endif

  cdm8_err_stats #(.SUM_W(SUM_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .n_samples(n_samples),
    .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .r(r),
    .busy(busy), .done(done), .sample_cnt(sample_cnt), .err_cnt(err_cnt),
    .sum_ed(sum_ed), .max_ed(max_ed), .max_a(max_a), .max_b(max_b)
`ifdef CDM_ERR_BIAS_EN
    , .bias_sum(bias_sum)
`endif
  );

  cdm8_err_stats #(.SUM_W(SUM2_W), .CNT_W(CNT_W)) dut2 (
    .clk(clk), .rst(rst), .start(start), .n_samples(n_samples),
    .in_valid(in_valid), .in_ready(in_ready2), .a(a), .b(b), .r(r),
    .busy(busy2), .done(done2), .sample_cnt(sample_cnt2), .err_cnt(err_cnt2),
    .sum_ed(sum_ed2), .max_ed(max_ed2), .max_a(max_a2), .max_b(max_b2)
`ifdef CDM_ERR_BIAS_EN
    , .bias_sum(bias_sum2)
`endif
  );

  always #5 clk = ~clk;

  int     vec_cnt = 0;
  int     bad_cnt = 0;
  int     xfers, ready_bad, done_cnt, cyc_done;
  trip_t  stim_q[$];
  longint m_samp, m_err, m_sum, m_sum2, m_max, m_ma, m_mb, m_bias, m_bias2;

  task automatic check(input string name, input longint act, input longint exp);
    vec_cnt++;
    if (act !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic longint clamp(input longint v, input longint lo, input longint hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  task automatic model_clear();
    m_samp = 0; m_err = 0; m_sum = 0; m_sum2 = 0;
    m_max = 0; m_ma = 0; m_mb = 0; m_bias = 0; m_bias2 = 0;
  endtask

  // Reference: error distance and signed error from plain integer arithmetic.
  task automatic model_add(input trip_t t);
    longint ex, d, e;
    ex = longint'(t.a) * longint'(t.b);
    d  = longint'(t.r) - ex;
    e  = (d < 0) ? -d : d;
    m_samp++;
    if (e != 0) m_err++;
    m_sum  = clamp(m_sum + e, 0, SUM_MAX);
    m_sum2 = clamp(m_sum2 + e, 0, SUM2_MAX);
    if (e > m_max) begin
      m_max = e; m_ma = t.a; m_mb = t.b;
    end
    m_bias  = clamp(m_bias + d, B_MIN, B_MAX);
    m_bias2 = clamp(m_bias2 + d, B2_MIN, B2_MAX);
  endtask

  function automatic trip_t rand_trip();
    trip_t t;
    int    ex, v;
    t.a = 8'($urandom);
    t.b = 8'($urandom);
    ex  = int'(t.a) * int'(t.b);
    case ($urandom_range(0, 3))
      1:       v = ex + int'($urandom_range(0, 64)) - 32;
      2:       v = int'($urandom_range(0, 65535));
      default: v = ex;
    endcase
    if (v < 0) v = 0;
    if (v > 65535) v = 65535;
    t.r = 16'(v);
    return t;
  endfunction

  task automatic check_model(input string p);
    check({p, "_sample_cnt"}, sample_cnt, m_samp);
    check({p, "_err_cnt"}, err_cnt, m_err);
    check({p, "_sum_ed"}, sum_ed, m_sum);
    check({p, "_max_ed"}, max_ed, m_max);
    check({p, "_max_a"}, max_a, m_ma);
    check({p, "_max_b"}, max_b, m_mb);
    check({p, "_sum_ed_narrow"}, sum_ed2, m_sum2);
`ifdef CDM_ERR_BIAS_EN
    check({p, "_bias_sum"}, bias_sum, m_bias);
    check({p, "_bias_sum_narrow"}, bias_sum2, m_bias2);
`endif
  endtask

  // One complete run; triples come from stim_q in order, extra ones are offered and must be dropped.
  task automatic run_pass(input string p, input int n, input bit tog, input bit poke);
    int cyc, last_x, limit;
    bit got;
    xfers = 0; ready_bad = 0; done_cnt = 0; cyc_done = -1; last_x = -1;
    limit = 4 * n + 40;
    model_clear();
    @(negedge clk);
    n_samples = CNT_W'(n);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_samples = CNT_W'(n + 7);
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < limit) begin
      if (poke) start = (cyc == 2);
      in_valid = (stim_q.size() > 0) && (!tog || (cyc % 2 == 0));
      if (stim_q.size() > 0) begin
        a = stim_q[0].a; b = stim_q[0].b; r = stim_q[0].r;
      end else begin
        a = 8'($urandom); b = 8'($urandom); r = 16'($urandom);
      end
      if (in_ready !== (xfers < n)) ready_bad++;
      if (in_valid && in_ready) begin
        model_add(stim_q.pop_front());
        xfers++;
        last_x = cyc;
      end
      @(posedge clk);
      #1;
      if (done) begin
        got = 1'b1; done_cnt++; cyc_done = cyc;
      end
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    start = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
      if (done) done_cnt++;
      @(negedge clk);
    end
    stim_q.delete();
    check({p, "_done_pulses"}, done_cnt, 1);
    check({p, "_transfers"}, xfers, n);
    check({p, "_ready_profile"}, ready_bad, 0);
    check({p, "_busy_after"}, busy, 0);
    if (n == 0) check({p, "_done_within_3"}, (cyc_done >= 0 && cyc_done <= 2), 1);
    else check({p, "_done_latency"}, cyc_done - last_x, 3);
  endtask

  vec_t vt[4];

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    trip_t t;
    int    k;
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; n_samples = '0;
    a = '0; b = '0; r = '0;

    vt[0] = '{n:4, nt:4, tog:1'b0,
              ta:{8'd16, 8'd0, 8'd255, 8'd3}, tb:{8'd16, 8'd7, 8'd255, 8'd5},
              tr:{16'd256, 16'd0, 16'd65025, 16'd15},
              e_samp:4, e_err:0, e_sum:0, e_max:0, e_ma:0, e_mb:0, e_bias:0};
    vt[1] = '{n:3, nt:3, tog:1'b0,
              ta:{8'd0, 8'd12, 8'd200, 8'd10}, tb:{8'd0, 8'd12, 8'd3, 8'd10},
              tr:{16'd0, 16'd144, 16'd608, 16'd96},
              e_samp:3, e_err:2, e_sum:12, e_max:8, e_ma:200, e_mb:3, e_bias:4};
    vt[2] = '{n:2, nt:4, tog:1'b1,
              ta:{8'd1, 8'd5, 8'd20, 8'd7}, tb:{8'd1, 8'd5, 8'd20, 8'd9},
              tr:{16'd99, 16'd30, 16'd390, 16'd63},
              e_samp:2, e_err:1, e_sum:10, e_max:10, e_ma:20, e_mb:20, e_bias:-10};
    vt[3] = '{n:0, nt:0, tog:1'b0, ta:'0, tb:'0, tr:'0,
              e_samp:0, e_err:0, e_sum:0, e_max:0, e_ma:0, e_mb:0, e_bias:0};

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_sample_cnt", sample_cnt, 0);
    check("rst_err_cnt", err_cnt, 0);
    check("rst_sum_ed", sum_ed, 0);
    check("rst_max", {max_ed, max_a, max_b}, 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 4; i++) begin
      string p;
      p = $sformatf("vec%0d", i);
      for (int j = 0; j < vt[i].nt; j++) begin
        t.a = vt[i].ta[j]; t.b = vt[i].tb[j]; t.r = vt[i].tr[j];
        stim_q.push_back(t);
      end
      run_pass(p, vt[i].n, vt[i].tog, 1'b0);
      check({p, "_sample_cnt"}, sample_cnt, vt[i].e_samp);
      check({p, "_err_cnt"}, err_cnt, vt[i].e_err);
      check({p, "_sum_ed"}, sum_ed, vt[i].e_sum);
      check({p, "_max_ed"}, max_ed, vt[i].e_max);
      check({p, "_max_a"}, max_a, vt[i].e_ma);
      check({p, "_max_b"}, max_b, vt[i].e_mb);
`ifdef CDM_ERR_BIAS_EN
      check({p, "_bias_sum"}, bias_sum, vt[i].e_bias);
`endif
    end

    // Large errors: narrow instance saturates, ties keep the first maximum.
    for (int j = 0; j < 3; j++) begin
      t.a = 8'd255; t.b = 8'd255; t.r = 16'd0;
      stim_q.push_back(t);
    end
    t.a = 8'd0; t.b = 8'd0; t.r = 16'd60000;
    stim_q.push_back(t);
    run_pass("sat", 4, 1'b0, 1'b0);
    check_model("sat");
    check("sat_narrow_sum_is_max", sum_ed2, SUM2_MAX);

    // Abort: reset after 5 of 10 accepts.
    for (int j = 0; j < 10; j++) stim_q.push_back(rand_trip());
    @(negedge clk);
    n_samples = CNT_W'(10);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    xfers = 0;
    k = 0;
    while (xfers < 5 && k < 50) begin
      in_valid = 1'b1;
      a = stim_q[0].a; b = stim_q[0].b; r = stim_q[0].r;
      if (in_ready) begin
        void'(stim_q.pop_front());
        xfers++;
      end
      @(negedge clk);
      k++;
    end
    check("abort_accepts", xfers, 5);
    rst = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("abort_busy", busy, 0);
    check("abort_in_ready", in_ready, 0);
    check("abort_done", done, 0);
    check("abort_stats", {sample_cnt, err_cnt, sum_ed, max_ed, max_a, max_b}, 0);
    @(negedge clk);
    rst = 1'b0;
    done_cnt = 0;
    repeat (4) begin
      @(posedge clk);
      #1;
      if (done || busy) done_cnt++;
      @(negedge clk);
    end
    check("abort_quiet", done_cnt, 0);
    stim_q.delete();
    for (int j = 0; j < 12; j++) stim_q.push_back(rand_trip());
    run_pass("after_abort", 10, 1'b0, 1'b0);
    check_model("after_abort");

    // Randomized runs, back to back; one ignores a mid-run start.
    for (int i = 0; i < 12; i++) begin
      int n;
      string p;
      p = $sformatf("rnd%0d", i);
      n = (i == 11) ? 1500 : int'($urandom_range(5, 40));
      for (int j = 0; j < n + 3; j++) stim_q.push_back(rand_trip());
      run_pass(p, n, 1'($urandom_range(0, 1)), (i == 3));
      check_model(p);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, bad_cnt);
    $finish;
  end

endmodule
